// File: rtl/byte_unstrip.sv
// byte_unstrip: collects 4-lane symbol words in a small FIFO and re-serializes them lane 0 first,
// collapsing replicated ordered sets to one symbol. Define BYTE_UNSTRIP_SKP_DROP_EN to discard SKP sets.
module byte_unstrip #(
  parameter int DEPTH     = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [7:0]           LANE0,
  input  logic [7:0]           LANE1,
  input  logic [7:0]           LANE2,
  input  logic [7:0]           LANE3,
  input  logic                 DK_0,
  input  logic                 DK_1,
  input  logic                 DK_2,
  input  logic                 DK_3,
  output logic                 OUT_VALID,
  output logic [7:0]           D,
  output logic                 DK,
  output logic                 ERROR_LANE,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_IDL = 8'h7C;
  localparam logic [7:0] K_FTS = 8'h3C;

`ifdef BYTE_UNSTRIP_SKP_DROP_EN
  localparam bit SKP_DROP_EN = 1'b1;
`else
  localparam bit SKP_DROP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_L0,
    S_L1,
    S_L2,
    S_L3,
    S_OS
  } state_t;

  // Word layout: [35:32] = DK_3..DK_0, [31:0] = LANE3..LANE0.
  function automatic logic is_os_sym(input logic [7:0] b);
    return (b == K_COM) || (b == K_SKP) || (b == K_IDL) || (b == K_FTS);
  endfunction

  function automatic logic is_os_word(input logic [35:0] w);
    return (&w[35:32]) &&
           (w[15:8] == w[7:0]) && (w[23:16] == w[7:0]) && (w[31:24] == w[7:0]) &&
           is_os_sym(w[7:0]);
  endfunction

  function automatic logic is_bad_word(input logic [35:0] w);
    logic any_k;
    any_k = 1'b0;
    for (int k = 0; k < 4; k++) begin
      any_k = any_k | (w[32+k] & is_os_sym(w[8*k +: 8]));
    end
    return any_k && !is_os_word(w);
  endfunction

  function automatic logic is_drop_word(input logic [35:0] w);
    return SKP_DROP_EN && is_os_word(w) && (w[7:0] == K_SKP);
  endfunction

  logic [35:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  state_t        r_state;

  state_t        w_state_nx;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_has_after;
  logic [35:0]   w_in_word;
  logic [35:0]   w_head;
  logic [35:0]   w_after;
  logic [35:0]   w_cand;
  logic          w_cand_vld;
  logic          w_load;
  logic          w_ov_nx;
  logic [7:0]    w_d_nx;
  logic          w_dk_nx;
  logic          w_err_nx;

  assign w_in_word   = {DK_3, DK_2, DK_1, DK_0, LANE3, LANE2, LANE1, LANE0};
  assign IN_READY    = (r_count != CW'(DEPTH));
  assign w_push      = IN_VALID & IN_READY;
  assign w_empty     = (r_count == '0);
  assign w_has_after = (r_count >= CW'(2));
  assign w_head      = r_mem[r_rd_ptr];
  assign w_after     = r_mem[r_rd_ptr + AW'(1)];

  // NOTE: the word storage carries no reset; validity is tracked by the count, so clearing it buys nothing.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_word;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Outputs are registered: the next-state logic computes what the coming state will display.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_nx = r_state;
    w_pop      = 1'b0;
    w_cand     = w_head;
    w_cand_vld = 1'b0;
    w_load     = 1'b0;
    w_ov_nx    = 1'b0;
    w_d_nx     = 8'h00;
    w_dk_nx    = 1'b0;
    w_err_nx   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_load     = 1'b1;
        w_cand     = w_head;
        w_cand_vld = !w_empty;
        if (!w_empty && is_drop_word(w_head)) begin
          w_pop      = 1'b1;
          w_cand     = w_after;
          w_cand_vld = w_has_after;
        end
      end
      S_L0: begin
        w_state_nx = S_L1;
        w_ov_nx    = 1'b1;
        w_d_nx     = w_head[15:8];
        w_dk_nx    = w_head[33];
      end
      S_L1: begin
        w_state_nx = S_L2;
        w_ov_nx    = 1'b1;
        w_d_nx     = w_head[23:16];
        w_dk_nx    = w_head[34];
      end
      S_L2: begin
        w_state_nx = S_L3;
        w_ov_nx    = 1'b1;
        w_d_nx     = w_head[31:24];
        w_dk_nx    = w_head[35];
      end
      S_L3, S_OS: begin
        // Head retires now; the word behind it starts without a bubble when already buffered.
        w_pop      = 1'b1;
        w_load     = 1'b1;
        w_cand     = w_after;
        w_cand_vld = w_has_after;
      end
      default: w_state_nx = S_IDLE;
    endcase

    if (w_load) begin
      w_state_nx = S_IDLE;
      if (w_cand_vld && !is_drop_word(w_cand)) begin
        w_ov_nx = 1'b1;
        w_d_nx  = w_cand[7:0];
        if (is_os_word(w_cand)) begin
          w_state_nx = S_OS;
          w_dk_nx    = 1'b1;
        end else begin
          w_state_nx = S_L0;
          w_dk_nx    = w_cand[32];
          w_err_nx   = is_bad_word(w_cand);
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      OUT_VALID  <= 1'b0;
      D          <= 8'h00;
      DK         <= 1'b0;
      ERROR_LANE <= 1'b0;
      ERR_CNT    <= '0;
    end else begin
      r_state    <= w_state_nx;
      OUT_VALID  <= w_ov_nx;
      D          <= w_d_nx;
      DK         <= w_dk_nx;
      ERROR_LANE <= w_err_nx;
      if (w_err_nx && (ERR_CNT != '1)) begin
        ERR_CNT <= ERR_CNT + ERR_CNT_W'(1);
      end
    end
  end

`ifndef SYNTHESIS
  a_count_bound : assert property (@(posedge CLK) disable iff (RESET) r_count <= CW'(DEPTH));
  a_no_underflow : assert property (@(posedge CLK) disable iff (RESET) w_pop |-> !w_empty);
  a_err_with_data : assert property (@(posedge CLK) disable iff (RESET) ERROR_LANE |-> OUT_VALID);
`endif

endmodule
